// File: rtl/serial_in_rx_pkg.sv
// Shared definitions for the serial link receiver: FSM state encoding and frame bit levels.
package serial_in_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_sync.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 (idle line level).
module serial_sync (
  input  logic clk,
  input  logic r,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (r) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_in_rx.sv
// Serial-to-parallel receiver: start bit, WIDTH data bits LSB first, stop bit, sampled mid-bit.
module serial_in_rx
  import serial_in_rx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             r,
  input  logic             din,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW   = $clog2(WIDTH) + 1;

  rx_state_t        state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg;
  logic             din_s;

  serial_sync u_sync (
    .clk (clk),
    .r   (r),
    .d   (din),
    .q   (din_s)
  );

  // Frame FSM; valid/frame_err default low so each is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (r) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (din_s == START_BIT) begin
            cnt   <= CW'(HALF - 1);
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (din_s == START_BIT) begin
              cnt   <= CW'(CLKS_PER_BIT - 1);
              idx   <= '0;
              state <= DATA;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg <= WIDTH'({din_s, shreg} >> 1);
            cnt   <= CW'(CLKS_PER_BIT - 1);
            if (idx == IW'(WIDTH - 1)) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (din_s == STOP_BIT) begin
              data_out <= shreg;
              valid    <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line is released so a break cannot look like a new start.
          if (din_s == STOP_BIT) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_in_rx.sv
// Directed bench for serial_in_rx: frame-level reference model compared against the DUT every cycle.
module tb_serial_in_rx;

  localparam int unsigned W    = 8;
  localparam int unsigned CPB  = 4;
  localparam int unsigned HALF = CPB / 2;
  localparam int          MAXN = 1000;

  logic         clk;
  logic         r;
  logic         din;
  logic [W-1:0] data_out;
  logic         valid;
  logic         frame_err;
  logic         busy;

  serial_in_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .r         (r),
    .din       (din),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus per posedge index, and expected outputs just after that posedge.
  logic         din_v    [MAXN];
  logic         r_v      [MAXN];
  logic         exp_valid[MAXN];
  logic         exp_err  [MAXN];
  logic         exp_busy [MAXN];
  logic [W-1:0] exp_data [MAXN];
  logic [W-1:0] word_at  [MAXN];

  int ptr;
  int ncyc;
  int cyc;
  int total;
  int bad;
  bit model_ready;
  int s1, s2, s3, s4, s5, s5b, s6, s7;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic put(input logic b, input int n, input logic rr = 1'b0);
    for (int i = 0; i < n; i++) begin
      din_v[ptr] = b;
      r_v[ptr]   = rr;
      ptr++;
    end
  endtask

  task automatic frame(input logic [W-1:0] w, input logic stopb);
    put(1'b0, CPB);
    for (int k = 0; k < W; k++) put(w[k], CPB);
    put(stopb, CPB);
  endtask

  // Line level seen by the receiver logic at posedge e (two-flop delay, reset forces idle).
  function automatic logic dins(input int e);
    if (e < 2 || e - 2 >= MAXN) return 1'b1;
    if (r_v[e-1] || r_v[e-2]) return 1'b1;
    return din_v[e-2];
  endfunction

  task automatic mark_busy(input int a, input int b);
    for (int i = a; i <= b; i++) if (i >= 0 && i < MAXN) exp_busy[i] = 1'b1;
  endtask

  // Frame-level decode: find start, check mid-start, sample bits at mid-bit times, judge the stop bit.
  task automatic build_model();
    int c, t, e, q, f;
    logic ok;
    logic [W-1:0] w;
    logic [W-1:0] cur;
    for (int i = 0; i < MAXN; i++) begin
      exp_valid[i] = 1'b0;
      exp_err[i]   = 1'b0;
      exp_busy[i]  = 1'b0;
      word_at[i]   = '0;
    end
    c = 0;
    while (c < ncyc) begin
      if (r_v[c]) begin c++; continue; end
      if (dins(c)) begin c++; continue; end
      t  = c;
      ok = !dins(t + HALF);
      e  = ok ? t + HALF + (W + 1) * CPB : t + HALF;
      q  = -1;
      for (int i = t + 1; i <= e && i < ncyc; i++) if (r_v[i] && q < 0) q = i;
      if (q >= 0) begin
        mark_busy(t, q - 1);
        c = q;
        continue;
      end
      mark_busy(t, e - 1);
      if (!ok) begin c = e + 1; continue; end
      for (int k = 0; k < W; k++) w[k] = dins(t + HALF + (k + 1) * CPB);
      if (dins(e)) begin
        if (e < MAXN) begin exp_valid[e] = 1'b1; word_at[e] = w; end
        c = e + 1;
      end else begin
        if (e < MAXN) exp_err[e] = 1'b1;
        f = e + 1;
        while (f < ncyc && !r_v[f] && !dins(f)) f++;
        mark_busy(e, f - 1);
        c = (f < ncyc && r_v[f]) ? f : f + 1;
      end
    end
    cur = '0;
    for (int i = 0; i < MAXN; i++) begin
      if (i < ncyc && r_v[i]) cur = '0;
      else if (exp_valid[i]) cur = word_at[i];
      exp_data[i] = cur;
    end
  endtask

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int e;
    if (model_ready && cyc >= 1 && cyc - 1 < ncyc) begin
      e = cyc - 1;
      total += 4;
      if (data_out !== exp_data[e]) begin
        bad++;
        $display("FAIL data_out edge=%0d got=%0h exp=%0h", e, data_out, exp_data[e]);
      end
      if (valid !== exp_valid[e]) begin
        bad++;
        $display("FAIL valid edge=%0d got=%0b exp=%0b", e, valid, exp_valid[e]);
      end
      if (frame_err !== exp_err[e]) begin
        bad++;
        $display("FAIL frame_err edge=%0d got=%0b exp=%0b", e, frame_err, exp_err[e]);
      end
      if (busy !== exp_busy[e]) begin
        bad++;
        $display("FAIL busy edge=%0d got=%0b exp=%0b", e, busy, exp_busy[e]);
      end
    end
  end

  initial begin
    int nz;
    cyc = 0; total = 0; bad = 0; ptr = 0; model_ready = 0;
    for (int i = 0; i < MAXN; i++) begin din_v[i] = 1'b1; r_v[i] = 1'b0; end

    put(1'b1, 3, 1'b1);
    put(1'b1, 5);
    s1 = ptr; frame(8'hA5, 1'b1); put(1'b1, 10);
    s2 = ptr; put(1'b0, 1); put(1'b1, 10);
    s3 = ptr; frame(8'h3C, 1'b0); put(1'b0, 20); put(1'b1, 20);
    s4 = ptr; frame(8'h00, 1'b1); frame(8'hFF, 1'b1); put(1'b1, 10);
    s5 = ptr; frame(8'h96, 1'b1);
    r_v[s5 + 18] = 1'b1;
    for (int i = s5 + 18; i < ptr; i++) din_v[i] = 1'b1;
    put(1'b1, 10);
    s5b = ptr; frame(8'h5A, 1'b1); put(1'b1, 10);
    s6 = ptr;
    for (int i = 0; i < 30; i++) put(1'($urandom), 1, 1'b1);
    put(1'b1, 10);
    s7 = ptr; frame(8'hC3, 1'b1); put(1'b1, 60);
    ncyc = ptr;

    build_model();

    // Hand-derived anchors for the model.
    chk("m_busy_before", 32'(exp_busy[s1 + 1]), 0);
    chk("m_busy_rise", 32'(exp_busy[s1 + 2]), 1);
    chk("m_busy_last", 32'(exp_busy[s1 + 39]), 1);
    chk("m_busy_fall", 32'(exp_busy[s1 + 40]), 0);
    chk("m_valid_early", 32'(exp_valid[s1 + 39]), 0);
    chk("m_valid_a5", 32'(exp_valid[s1 + 40]), 1);
    chk("m_data_a5", 32'(exp_data[s1 + 40]), 32'hA5);
    chk("m_glitch_busy", 32'(exp_busy[s2 + 3]), 1);
    chk("m_glitch_drop", 32'(exp_busy[s2 + 4]), 0);
    chk("m_err_3c", 32'(exp_err[s3 + 40]), 1);
    chk("m_err_keep", 32'(exp_data[s3 + 40]), 32'hA5);
    chk("m_wait_busy", 32'(exp_busy[s3 + 61]), 1);
    chk("m_wait_free", 32'(exp_busy[s3 + 62]), 0);
    chk("m_b2b_first", 32'(exp_valid[s4 + 40]), 1);
    chk("m_b2b_d0", 32'(exp_data[s4 + 40]), 32'h00);
    chk("m_b2b_second", 32'(exp_valid[s4 + 80]), 1);
    chk("m_b2b_d1", 32'(exp_data[s4 + 80]), 32'hFF);
    chk("m_rst_data", 32'(exp_data[s5 + 18]), 0);
    chk("m_rst_busy", 32'(exp_busy[s5 + 18]), 0);
    chk("m_post_rst", 32'(exp_data[s5b + 40]), 32'h5A);
    chk("m_recover", 32'(exp_data[s7 + 40]), 32'hC3);
    nz = 0;
    for (int i = s6; i < s6 + 30; i++)
      if (exp_valid[i] || exp_err[i] || exp_busy[i] || exp_data[i] != '0) nz++;
    chk("m_rst_hold", nz, 0);

    model_ready = 1;
    din = din_v[0];
    r   = r_v[0];
    while (cyc < ncyc) begin
      @(negedge clk);
      if (cyc < ncyc) begin
        din = din_v[cyc];
        r   = r_v[cyc];
      end
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
